cpu_step_clock: RTL

CPU_STEP_CLOCK -- requirements
Module: cpu_step_clock

---
 rtl/cpu_step_clock.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cpu_step_clock.sv
// Step/run clock-enable generator for a hand-clocked CPU: debounces a push-button
// into single-instruction steps, or free-runs from a prescaler when run is set.
module cpu_step_clock #(
    parameter int clk_mhz         = 50,
    parameter int debounce_cycles = clk_mhz * 1000,
    parameter int run_period      = clk_mhz * 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step_key,
    output logic        cpu_en,
    output logic [31:0] step_count,
    output logic        key_held
);

    localparam int db_w  = $clog2(debounce_cycles);
    localparam int pre_w = $clog2(run_period);
    localparam logic [db_w-1:0]  db_last  = db_w'(debounce_cycles - 1);
    localparam logic [pre_w-1:0] pre_last = pre_w'(run_period - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } state_t;

    logic             run_q1, run_s;
    logic             key_q1, key_s;
    state_t           state, state_next;
    logic [db_w-1:0]  db_cnt;
    logic [pre_w-1:0] pre_cnt;
    logic             step_req;
    logic             run_wrap;
    logic             cpu_en_next;

    // Both raw inputs are asynchronous to clk; only the second flop is used.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, which is what makes the two-flop chain a real 2-cycle delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q1 <= 1'b0;
            run_s  <= 1'b0;
            key_q1 <= 1'b0;
            key_s  <= 1'b0;
        end else begin
            run_q1 <= run;
            run_s  <= run_q1;
            key_q1 <= step_key;
            key_s  <= key_q1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        step_req   = 1'b0;
        case (state)
            IDLE: begin
                if (key_s) state_next = PRESS_DB;
            end
            PRESS_DB: begin
                if (!key_s) begin
                    state_next = IDLE;
                end else if (db_cnt == db_last) begin
                    state_next = HELD;
                    step_req   = 1'b1;
                end
            end
            HELD: begin
                if (!key_s) state_next = REL_DB;
            end
            REL_DB: begin
                if (key_s) begin
                    state_next = HELD;
                end else if (db_cnt == db_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            state <= state_next;
            // One counter serves both debounce states; any transition restarts it.
            if (state_next != state) begin
                db_cnt <= '0;
            end else if ((state == PRESS_DB || state == REL_DB) && db_cnt != db_last) begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign run_wrap = run_s && (pre_cnt == pre_last);

    // Step requests are dropped in run mode; the !cpu_en term keeps a run pulse and
    // a step pulse from landing on adjacent cycles at a mode switch.
    assign cpu_en_next = (run_wrap || (step_req && !run_s)) && !cpu_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt    <= '0;
            cpu_en     <= 1'b0;
            step_count <= '0;
        end else begin
            if (!run_s || run_wrap) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            cpu_en <= cpu_en_next;
            if (cpu_en) begin
                step_count <= step_count + 32'd1;
            end
        end
    end

    assign key_held = (state == HELD) || (state == REL_DB);

endmodule
